reg_file_sweep: RTL and testbench

//  Parametrised multi-read-port register file with a bypassed write port and a sequential clear engine.

---
 rtl/reg_file_sweep.sv | 108 ++++++++++
 tb/tb_reg_file_sweep.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sweep.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sweep
// Brief    : Parametrised multi-read-port register file with a forwarded write
//            port and a one-entry-per-cycle clear sweep.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_sweep #(
    parameter int BITS     = 16,
    parameter int SEL      = 3,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [SEL-1:0]         wr_sel,
    input  logic [BITS-1:0]        wr_data,
    output logic                   wr_ready,
    input  logic [NUM_RD*SEL-1:0]  rd_sel,
    output logic [NUM_RD*BITS-1:0] rd_data,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   clr_done
);
    localparam int             DEPTH      = 2**SEL;
    localparam logic [0:0]     c_IDLE     = 1'b0;
    localparam logic [0:0]     c_CLEAR    = 1'b1;
    localparam logic [SEL-1:0] c_LAST_PTR = SEL'(DEPTH - 1);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [BITS-1:0] mem_d [DEPTH];
    logic [0:0]      state_q, state_d;
    logic [SEL-1:0]  ptr_q, ptr_d;
    logic            clr_done_q, clr_done_d;
    logic            w_wr_accept;

    // A pending clear request blocks the write in the same cycle: clear wins.
    assign wr_ready    = (state_q == c_IDLE) && !clr_req;
    assign w_wr_accept = wr_en && wr_ready;
    assign busy        = (state_q == c_CLEAR);
    assign clr_done    = clr_done_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        mem_d      = mem_q;
        case (state_q)
            c_IDLE: begin
                if (clr_req) begin
                    state_d = c_CLEAR;
                end else if (w_wr_accept && !(ZERO_REG != 0 && wr_sel == '0)) begin
                    mem_d[wr_sel] = wr_data;
                end
            end
            default: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + 1'b1;
                if (ptr_q == c_LAST_PTR) begin
                    state_d    = c_IDLE;
                    clr_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= c_IDLE;
            ptr_q      <= '0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [SEL-1:0]  w_sel;
            logic [BITS-1:0] w_data;

            assign w_sel = rd_sel[k*SEL +: SEL];

            // Hard-wired zero register takes precedence over forwarding.
            always_comb begin
                w_data = mem_q[w_sel];
                if (BYPASS != 0 && w_wr_accept && wr_sel == w_sel) begin
                    w_data = wr_data;
                end
                if (ZERO_REG != 0 && w_sel == '0) begin
                    w_data = '0;
                end
            end

            assign rd_data[k*BITS +: BITS] = w_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sweep
// Brief    : Self-checking bench for reg_file_sweep (default and ZERO_REG/32b/SEL4).
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_sweep;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0, clr_req = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [15:0] wr_data = '0;
    logic [8:0]  rd_sel = '0;
    logic [47:0] rd_data;
    logic        wr_ready, busy, clr_done;

    logic        z_wr_en = 1'b0, z_clr_req = 1'b0;
    logic [3:0]  z_wr_sel = '0;
    logic [31:0] z_wr_data = '0;
    logic [11:0] z_rd_sel = '0;
    logic [95:0] z_rd_data;
    logic        z_wr_ready, z_busy, z_clr_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_sweep u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_sel(rd_sel), .rd_data(rd_data), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done)
    );

    reg_file_sweep #(.BITS(32), .SEL(4), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) u_zero (
        .clk(clk), .rst(rst), .wr_en(z_wr_en), .wr_sel(z_wr_sel), .wr_data(z_wr_data),
        .wr_ready(z_wr_ready), .rd_sel(z_rd_sel), .rd_data(z_rd_data), .clr_req(z_clr_req),
        .busy(z_busy), .clr_done(z_clr_done)
    );

    typedef struct {
        string       name;
        logic [47:0] rd;
        logic        rdy;
        logic        bsy;
        logic        done;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  ws;
        logic [15:0] wd;
        logic [2:0]  s0, s1, s2;
        logic [15:0] e0, e1, e2;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive after the edge, queue the expectation, compare on the falling edge.
    task automatic step(input string name, input logic we, input logic [2:0] ws,
                        input logic [15:0] wd, input logic cr,
                        input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                        input logic erdy, input logic ebsy, input logic edone);
        exp_t e;
        wr_en   = we;
        wr_sel  = ws;
        wr_data = wd;
        clr_req = cr;
        rd_sel  = {s2, s1, s0};
        exp_q.push_back('{name, {e2, e1, e0}, erdy, ebsy, edone});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.name, ".rd"},   64'(rd_data),  64'(e.rd));
        chk({e.name, ".rdy"},  64'(wr_ready), 64'(e.rdy));
        chk({e.name, ".busy"}, 64'(busy),     64'(e.bsy));
        chk({e.name, ".done"}, 64'(clr_done), 64'(e.done));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 3'd5, 16'h1234, 3'd0, 3'd5, 3'd2, 16'h0000, 16'h1234, 16'h0000};
        tbl[1] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 3'd5, 16'h0000, 16'h1234, 16'h1234};
        tbl[2] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd5, 3'd3, 16'hBEEF, 16'h1234, 16'hBEEF};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 3'd0, 16'hBEEF, 16'hBEEF, 16'h0000};
        tbl[4] = '{1'b1, 3'd3, 16'h0001, 3'd3, 3'd5, 3'd6, 16'h0001, 16'h1234, 16'h0000};
        tbl[5] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd3, 3'd7, 16'hFFFF, 16'h0001, 16'h0000};
        tbl[6] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("por.rd", 64'(rd_data), 64'h0);
        chk("por.busy", 64'(busy), 64'h0);
        chk("por.rdy", 64'(wr_ready), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            step($sformatf("vec%0d", i), tbl[i].we, tbl[i].ws, tbl[i].wd, 1'b0,
                 tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].e0, tbl[i].e1, tbl[i].e2,
                 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            step($sformatf("fill%0d", i), 1'b1, 3'(i), 16'(8'hA0 + i), 1'b0,
                 3'(i), 3'(i - 1), 3'd5,
                 16'(8'hA0 + i), (i == 0) ? 16'h0000 : 16'(8'hA0 + i - 1),
                 (i < 5) ? 16'h1234 : 16'h00A5,
                 1'b1, 1'b0, 1'b0);
        end

        step("clr_start", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd3, 3'd7,
             16'h00A0, 16'h00A3, 16'h00A7, 1'b0, 1'b0, 1'b0);
        // Write refused at cycle 2, clear re-request ignored at cycle 4
        for (int j = 0; j < 8; j++) begin
            step($sformatf("sweep%0d", j), (j == 2), 3'd2, 16'hDEAD, (j == 4),
                 3'(j), 3'(j - 1), 3'd7,
                 16'(8'hA0 + j), (j == 0) ? 16'h00A7 : 16'h0000, 16'h00A7,
                 1'b0, 1'b1, 1'b0);
        end
        step("clr_end", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd7,
             16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        step("post_clr", 1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd5, 3'd6,
             16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        step("pre_w1", 1'b1, 3'd1, 16'h0077, 1'b0, 3'd1, 3'd7, 3'd0,
             16'h0077, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        step("pre_w7", 1'b1, 3'd7, 16'h1111, 1'b0, 3'd7, 3'd1, 3'd0,
             16'h1111, 16'h0077, 16'h0, 1'b1, 1'b0, 1'b0);
        step("coll", 1'b1, 3'd1, 16'h0055, 1'b1, 3'd1, 3'd7, 3'd0,
             16'h0077, 16'h1111, 16'h0, 1'b0, 1'b0, 1'b0);
        step("coll_c0", 1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd7, 3'd0,
             16'h0077, 16'h1111, 16'h0, 1'b0, 1'b1, 1'b0);
        step("coll_c1", 1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd7, 3'd0,
             16'h0077, 16'h1111, 16'h0, 1'b0, 1'b1, 1'b0);
        step("coll_c2", 1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd7, 3'd0,
             16'h0000, 16'h1111, 16'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in sweep cycle 3
        rd_sel = {3'd5, 3'd7, 3'd1};
        #1;
        chk("rst_pre.busy", 64'(busy), 64'h1);
        chk("rst_pre.rd7", 64'(rd_data[31:16]), 64'h1111);
        rst = 1'b0;
        #1;
        chk("rst_mid.rd", 64'(rd_data), 64'h0);
        chk("rst_mid.busy", 64'(busy), 64'h0);
        chk("rst_mid.rdy", 64'(wr_ready), 64'h1);
        chk("rst_mid.done", 64'(clr_done), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d.busy", i), 64'(busy), 64'h0);
            chk($sformatf("rst_after%0d.done", i), 64'(clr_done), 64'h0);
        end
        @(posedge clk);
        #1;

        // ZERO_REG=1, BITS=32, SEL=4 instance
        z_wr_en = 1'b1; z_wr_sel = 4'd0; z_wr_data = 32'hFFFF_FFFF;
        z_rd_sel = {4'd0, 4'd15, 4'd0};
        #1;
        chk("z_w0.rd0", 64'(z_rd_data[31:0]), 64'h0);
        chk("z_w0.rd1", 64'(z_rd_data[63:32]), 64'h0);
        @(posedge clk);
        #1;
        z_wr_en = 1'b1; z_wr_sel = 4'd15; z_wr_data = 32'hCAFE_F00D;
        #1;
        chk("z_r0.rd0", 64'(z_rd_data[31:0]), 64'h0);
        chk("z_w15.byp", 64'(z_rd_data[63:32]), 64'hCAFE_F00D);
        @(posedge clk);
        #1;
        z_wr_en = 1'b0;
        z_rd_sel = {4'd15, 4'd15, 4'd0};
        #1;
        chk("z_r15.rd", 64'(z_rd_data), 64'(96'hCAFE_F00D_CAFE_F00D_0000_0000));
        z_clr_req = 1'b1;
        @(posedge clk);
        #1;
        z_clr_req = 1'b0;
        begin
            int nbusy = 0;
            int ndone = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (z_busy) nbusy++;
                if (z_clr_done) ndone++;
            end
            chk("z_sweep.busy_cycles", 64'(nbusy), 64'd16);
            chk("z_sweep.done_pulses", 64'(ndone), 64'd1);
        end
        chk("z_after.rd", 64'(z_rd_data), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
